// File: rtl/hazard_controller_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_controller_pkg : FSM state encoding, forwarding codes and selector
// Rev 1.0
// ---------------------------------------------------------------------------
package hazard_controller_pkg;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd1;
  localparam logic [1:0] ST_FLUSH_PEND = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // A load in MEM has no data yet, so it never forwards from that stage.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic       mem_ld,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    if (mem_we && !mem_ld && (mem_rd != 5'd0) && (mem_rd == rs))
      return FWD_MEM;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_controller_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : saturating event counter, synchronous clear wins over inc
// Rev 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_controller : 5-stage pipeline stall/flush/forward control + counters
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_RegWEn,
  input  logic             ex_MemRead,
  input  logic [4:0]       mem_rd,
  input  logic             mem_RegWEn,
  input  logic             mem_MemRead,
  input  logic [4:0]       wb_rd,
  input  logic             wb_RegWEn,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             memwb_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       ForwardSelA,
  output logic [1:0]       ForwardSelB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [1:0] state_q, state_d;
  logic       pend_q, pend_d;
  logic       all_stall, lu_stall, br_flush, lu_flush;
  logic       load_use;

  assign load_use = ex_MemRead && ex_RegWEn && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    all_stall = 1'b0;
    lu_stall  = 1'b0;
    br_flush  = 1'b0;
    lu_flush  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          all_stall = 1'b1;
          state_d   = ST_MEM_WAIT;
          pend_d    = branch_taken;
        end else if (branch_taken) begin
          br_flush = 1'b1;
        end else if (load_use) begin
          lu_stall = 1'b1;
          lu_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        pend_d = pend_q || branch_taken;
        if (!dmem_ready)
          all_stall = 1'b1;
        else
          state_d = (pend_q || branch_taken) ? ST_FLUSH_PEND : ST_RUN;
      end
      ST_FLUSH_PEND: begin
        br_flush = 1'b1;
        pend_d   = 1'b0;
        state_d  = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Gate with rst_n so the combinational outputs are quiet during reset.
  assign pc_stall    = rst_n && (all_stall || lu_stall);
  assign ifid_stall  = rst_n && (all_stall || lu_stall);
  assign idex_stall  = rst_n && all_stall;
  assign exmem_stall = rst_n && all_stall;
  assign memwb_stall = rst_n && all_stall;
  assign ifid_flush  = rst_n && br_flush;
  assign idex_flush  = rst_n && (br_flush || lu_flush);

  assign ForwardSelA = fwd_sel(ex_rs1, mem_rd, mem_RegWEn, mem_MemRead, wb_rd, wb_RegWEn);
  assign ForwardSelB = fwd_sel(ex_rs2, mem_rd, mem_RegWEn, mem_MemRead, wb_rd, wb_RegWEn);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_stall),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rst_n && br_flush),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_controller : directed scoreboard bench for hazard_controller
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_RegWEn, ex_MemRead;
  logic       mem_RegWEn, mem_MemRead, wb_RegWEn;
  logic       branch_taken, dmem_req, dmem_ready, cnt_clr;

  logic        pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
  logic        ifid_flush, idex_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_stall, s_ifid_stall, s_idex_stall, s_exmem_stall, s_memwb_stall;
  logic        s_ifid_flush, s_idex_flush;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  hazard_controller #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_RegWEn(ex_RegWEn), .ex_MemRead(ex_MemRead),
    .mem_rd(mem_rd), .mem_RegWEn(mem_RegWEn), .mem_MemRead(mem_MemRead),
    .wb_rd(wb_rd), .wb_RegWEn(wb_RegWEn), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .ForwardSelA(fwd_a), .ForwardSelB(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_controller #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_RegWEn(ex_RegWEn), .ex_MemRead(ex_MemRead),
    .mem_rd(mem_rd), .mem_RegWEn(mem_RegWEn), .mem_MemRead(mem_MemRead),
    .wb_rd(wb_rd), .wb_RegWEn(wb_RegWEn), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .idex_stall(s_idex_stall),
    .exmem_stall(s_exmem_stall), .memwb_stall(s_memwb_stall),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .ForwardSelA(s_fwd_a), .ForwardSelB(s_fwd_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Control vector: {pc, ifid, idex, exmem, memwb stall, ifid, idex flush}
  localparam logic [6:0] V_IDLE  = 7'b0000000;
  localparam logic [6:0] V_STALL = 7'b1111100;
  localparam logic [6:0] V_LU    = 7'b1100001;
  localparam logic [6:0] V_FLUSH = 7'b0000011;

  function automatic logic [6:0] ctl();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall, ifid_flush, idex_flush};
  endfunction

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic expect_val(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t x;
    x = q.pop_front();
    n_total++;
    assert (obs === x.exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_RegWEn, ex_MemRead} = '0;
    {mem_RegWEn, mem_MemRead, wb_RegWEn} = '0;
    {branch_taken, dmem_req, dmem_ready, cnt_clr} = '0;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #3;
    expect_val("reset_ctl", {25'd0, V_IDLE});   check({25'd0, ctl()});
    expect_val("reset_stall_cnt", 32'd0);       check({16'd0, stall_cnt});
    expect_val("reset_flush_cnt", 32'd0);       check({16'd0, flush_cnt});
    cyc();
    rst_n = 1'b1;
    cyc();

    // Forwarding priority and boundaries
    mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; ex_rs2 = 5'd7;
    mem_RegWEn = 1'b1; wb_RegWEn = 1'b1;
    expect_val("fwdA_mem", 32'b10); #1 check({30'd0, fwd_a});
    expect_val("fwdB_mem", 32'b10);    check({30'd0, fwd_b});
    mem_MemRead = 1'b1;
    expect_val("fwdA_wb_load", 32'b01); #1 check({30'd0, fwd_a});
    mem_MemRead = 1'b0; ex_rs1 = 5'd0;
    expect_val("fwdA_x0", 32'b00); #1 check({30'd0, fwd_a});
    mem_RegWEn = 1'b0; wb_RegWEn = 1'b0; ex_rs2 = 5'd7;
    expect_val("fwdB_none", 32'b00); #1 check({30'd0, fwd_b});
    idle_inputs();
    clear_counters();

    // Load-use hit, then negatives
    ex_rd = 5'd5; ex_MemRead = 1'b1; ex_RegWEn = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    expect_val("loaduse_ctl", {25'd0, V_LU}); #1 check({25'd0, ctl()});
    cyc();
    ex_MemRead = 1'b0;
    expect_val("loaduse_release", {25'd0, V_IDLE}); #1 check({25'd0, ctl()});
    expect_val("loaduse_stall_cnt", 32'd1);            check({16'd0, stall_cnt});
    ex_MemRead = 1'b1; id_use_rs1 = 1'b0; id_rs2 = 5'd5;
    expect_val("loaduse_unused_src", {25'd0, V_IDLE}); #1 check({25'd0, ctl()});
    id_use_rs2 = 1'b1;
    expect_val("loaduse_rs2", {25'd0, V_LU}); #1 check({25'd0, ctl()});
    ex_rd = 5'd0; id_rs2 = 5'd0;
    expect_val("loaduse_x0", {25'd0, V_IDLE}); #1 check({25'd0, ctl()});
    ex_rd = 5'd5; id_rs2 = 5'd5; cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    idle_inputs();
    expect_val("clr_over_inc", 32'd0); #1 check({16'd0, stall_cnt});

    // Memory wait: three stalled cycles, released in the ready cycle
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_val("memwait_stall", {25'd0, V_STALL}); #1 check({25'd0, ctl()});
      cyc();
    end
    dmem_ready = 1'b1;
    expect_val("memwait_ready", {25'd0, V_IDLE}); #1 check({25'd0, ctl()});
    cyc();
    idle_inputs();
    expect_val("memwait_stall_cnt", 32'd3); #1 check({16'd0, stall_cnt});
    clear_counters();

    // Deferred branch flush during memory wait
    dmem_req = 1'b1;
    expect_val("defer_wait0", {25'd0, V_STALL}); #1 check({25'd0, ctl()});
    cyc();
    branch_taken = 1'b1;
    expect_val("defer_no_flush", {25'd0, V_STALL}); #1 check({25'd0, ctl()});
    cyc();
    branch_taken = 1'b0; dmem_ready = 1'b1;
    expect_val("defer_ready", {25'd0, V_IDLE}); #1 check({25'd0, ctl()});
    cyc();
    idle_inputs();
    expect_val("defer_flush", {25'd0, V_FLUSH}); #1 check({25'd0, ctl()});
    cyc();
    expect_val("defer_once", {25'd0, V_IDLE}); #1 check({25'd0, ctl()});
    expect_val("defer_flush_cnt", 32'd1);         check({16'd0, flush_cnt});
    clear_counters();

    // Load-use coincident with branch: flush only
    ex_rd = 5'd5; ex_MemRead = 1'b1; ex_RegWEn = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    branch_taken = 1'b1;
    expect_val("simul_ctl", {25'd0, V_FLUSH}); #1 check({25'd0, ctl()});
    cyc();
    idle_inputs();
    expect_val("simul_stall_cnt", 32'd0); #1 check({16'd0, stall_cnt});
    expect_val("simul_flush_cnt", 32'd1);    check({16'd0, flush_cnt});
    clear_counters();

    // Saturation with CNT_W=2, then reset in the middle of the wait
    dmem_req = 1'b1;
    repeat (5) cyc();
    expect_val("sat_cnt_w2", 32'd3);  check({30'd0, s_stall_cnt});
    expect_val("sat_cnt_w16", 32'd5); check({16'd0, stall_cnt});
    expect_val("midwait_stall", {25'd0, V_STALL}); check({25'd0, ctl()});
    #1 rst_n = 1'b0;
    #1;
    expect_val("rst_mid_ctl", {25'd0, V_IDLE}); check({25'd0, ctl()});
    expect_val("rst_mid_cnt", 32'd0);           check({16'd0, stall_cnt});
    expect_val("rst_mid_cnt_w2", 32'd0);        check({30'd0, s_stall_cnt});
    cyc();
    dmem_req = 1'b0;
    rst_n = 1'b1;
    cyc();
    // In MEM_WAIT this would stall; in RUN with no request it is idle
    expect_val("post_rst_run", {25'd0, V_IDLE}); #1 check({25'd0, ctl()});
    branch_taken = 1'b1;
    expect_val("post_rst_branch", {25'd0, V_FLUSH}); #1 check({25'd0, ctl()});
    cyc();
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports id_rs1 and id_rs2, input, 5 each: source registers of the instruction in ID.
REQ-005 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 each: the ID instruction actually reads rs1 / rs2.
REQ-006 SHALL have ports ex_rs1 and ex_rs2, input, 5 each: source registers of the instruction in EX.
REQ-007 SHALL have ports ex_rd (input, 5), ex_RegWEn (input, 1) and ex_MemRead (input, 1): destination, write enable and load flag of the EX instruction.
REQ-008 SHALL have ports mem_rd (input, 5), mem_RegWEn (input, 1) and mem_MemRead (input, 1): the same fields for the MEM instruction.
REQ-009 SHALL have ports wb_rd (input, 5) and wb_RegWEn (input, 1): destination and write enable of the WB instruction.
REQ-010 SHALL have port branch_taken, input, 1: the branch or jump resolved in EX redirects the PC.
REQ-011 SHALL have ports dmem_req (input, 1): MEM stage accesses data memory; and dmem_ready (input, 1): the access completes this cycle.
REQ-012 SHALL have port cnt_clr, input, 1: synchronous clear of both counters.
REQ-013 SHALL have ports pc_stall, ifid_stall and idex_stall, output, 1 each: hold the PC / IF-ID / ID-EX registers.
REQ-014 SHALL have ports exmem_stall and memwb_stall, output, 1 each: hold the EX-MEM / MEM-WB registers.
REQ-015 SHALL have ports ifid_flush and idex_flush, output, 1 each: load a bubble (NOP) into IF-ID / ID-EX.
REQ-016 SHALL have ports ForwardSelA and ForwardSelB, output, 2 each: ALU operand source, 00 regfile, 10 MEM stage, 01 WB stage.
REQ-017 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each: performance counters.

Function
REQ-018 SHALL implement FSM states RUN, MEM_WAIT and FLUSH_PEND.
REQ-019 SHALL, in RUN when dmem_req=1 and dmem_ready=0, assert all five stall outputs this cycle and go to MEM_WAIT.
REQ-020 SHALL, in MEM_WAIT, keep all stalls asserted while dmem_ready=0; on dmem_ready=1 it deasserts the stalls and returns to RUN, or to FLUSH_PEND if a flush is pending.
REQ-021 SHALL, when branch_taken=1 is sampled in RUN, assert ifid_flush and idex_flush in the same cycle, with no stall.
REQ-022 SHALL, when branch_taken=1 is sampled in MEM_WAIT, set a pending-flush flag instead of flushing.
REQ-023 SHALL, in FLUSH_PEND, assert ifid_flush and idex_flush for exactly one cycle, clear the pending flag and go to RUN.
REQ-024 SHALL detect load-use in RUN when ex_MemRead & ex_RegWEn & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
REQ-025 SHALL, on a load-use hit, assert pc_stall, ifid_stall and idex_flush for that cycle only, giving a one-bubble penalty.
REQ-026 SHALL apply priority for simultaneous events as memory wait > branch flush > load-use; a load-use hit coincident with branch_taken produces a flush only.
REQ-027 SHALL drive ForwardSelA=10 when mem_RegWEn & !mem_MemRead & mem_rd!=0 & mem_rd==ex_rs1; otherwise 01 when wb_RegWEn & wb_rd!=0 & wb_rd==ex_rs1; otherwise 00. ForwardSelB SHALL use the same rule against ex_rs2.
REQ-028 SHALL compute forwarding combinationally, independent of FSM state.
REQ-029 SHALL increment stall_cnt once per cycle in which pc_stall=1.
REQ-030 SHALL increment flush_cnt once per cycle in which idex_flush=1 due to a branch (either the direct or the pending flush).
REQ-031 SHALL saturate both counters at all-ones.
REQ-032 SHALL give cnt_clr priority over increment.

Reset
REQ-033 SHALL, while rst_n=0, force state RUN, clear the pending flag, clear both counters, and drive all stall and flush outputs to 0, independent of clk.
REQ-034 SHALL, on reset asserted mid-MEM_WAIT, discard the wait and any pending flush; after release the FSM is in RUN.

Structure
REQ-035 SHALL place the FSM state encoding and the ForwardSel codes (00/10/01) in the shared pipeline package.
REQ-036 SHALL instantiate one sub-module, sat_counter (parameter CNT_W; inputs inc and clr), twice.

Verification
REQ-037 SHALL cover load-use: lw x5 in EX (ex_rd=5, ex_MemRead=1), ID reads rs1=5 -> pc_stall=ifid_stall=idex_flush=1 for 1 cycle, stall_cnt=1.
REQ-038 SHALL cover forward priority: mem_rd=wb_rd=ex_rs1=7, both RegWEn=1 -> ForwardSelA=10; with mem_MemRead=1 -> ForwardSelA=01; with ex_rs1=0 -> 00.
REQ-039 SHALL cover memory wait: dmem_req=1 and dmem_ready=0 for 3 cycles, then 1 -> all stalls high for 3 cycles, low in the ready cycle, stall_cnt=3.
REQ-040 SHALL cover deferred flush: branch_taken=1 during MEM_WAIT -> no flush until ready, then ifid_flush=idex_flush=1 for exactly 1 cycle, flush_cnt=1.
REQ-041 SHALL cover simultaneous events: load-use hit with branch_taken=1 in RUN -> flushes only, pc_stall=0, stall_cnt unchanged.
REQ-042 SHALL cover reset and saturation: rst_n low mid-MEM_WAIT -> outputs 0, state RUN; with CNT_W=2, 5 stalled cycles -> stall_cnt=3.
